pipe_muldiv_ctrl: RTL and testbench
===================================

// Module: pipe_muldiv_ctrl
// PURPOSE
//   Sequencer for an iterative multiply/divide unit beside the pipelined EXE stage. Owns the HI/LO registers.
//   Accepts mult/div ops from ID and runs a 32-step shift-add or restoring-divide loop.
//   Raises a low-active stall (same sense as wpcir) while ID needs HI/LO or a second op before the result is final.
// PARAMETERS
//   WIDTH    32  operand/result width; HI and LO are each WIDTH bits
//   CNT_W    6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clock       in   1      system clock; all state updates on the rising edge
//   resetn      in   1      reset, synchronous and active-low
//   md_start    in   1      ID holds a mult/div op and ID_bubble is high (bubbles are low-active)
//   md_op       in   2      00 multu, 01 divu, 10 mult, 11 div
//   md_a        in   WIDTH  forwarded rs value (ID_q1)
//   md_b        in   WIDTH  forwarded rt value (ID_q2)
//   hilo_rd     in   1      ID holds mfhi/mflo
//   hi_we       in   1      ID holds mthi; data comes from md_a
//   lo_we       in   1      ID holds mtlo; data comes from md_a
//   md_wpcir    out  1      0 = stall PC/IF-ID; ANDed with the hazard unit's wpcir
//   md_busy     out  1      FSM is not IDLE
//   md_done     out  1      one-cycle pulse in the cycle HI/LO receive a result
//   hi          out  WIDTH  HI register
//   lo          out  WIDTH  LO register
// BEHAVIOUR
//   Reset (resetn=0 at an edge)
//     - state=IDLE, count=0, hi=lo=0, md_done=0, md_busy=0, md_wpcir=1.
//     - Reset during RUN or FIN aborts the op. No partial result reaches HI/LO.
//   FSM
//     - IDLE -> RUN on md_start: latch operands and op, count=0.
//     - RUN: one step per cycle; count++. After step 31 (count==31), go to FIN.
//     - FIN: do sign fix-up, write hi/lo, md_done=1, then return to IDLE.
//     - Divide with md_b==0 (checked in IDLE): go straight to FIN.
//       Result is hi=md_a, lo={WIDTH{1'b1}}. No trap.
//   Latency
//     - Start accepted at edge t. hi/lo hold the result after edge t+33 (t+2 for divide-by-zero).
//     - md_busy is 1 from t+1 through the FIN cycle.
//   Arithmetic
//     - Multiply: 2*WIDTH-bit accumulator; hi=product[63:32], lo=product[31:0].
//     - Divide: restoring; lo=quotient, hi=remainder.
//     - All internal values are unsigned magnitudes.
//   Stall: md_wpcir=0 when md_busy and any of md_start, hilo_rd, hi_we, lo_we is high.
//     - ID holds the instruction, so it is re-presented until FIN ends.
//     - IDLE start on the cycle after FIN is legal.
//   Move-to: hi_we/lo_we in IDLE write md_a at the edge.
//     - If asserted together with md_start, the start wins and the write is dropped.
//       The decoder never issues both together.
//   In FIN, a same-cycle hilo_rd stalls. The reader sees the new value next cycle; no bypass.
// CONFIGURATION
//   Macro PIPE_MULDIV_SIGNED_EN
//   - Defined: md_op[1]=1 selects signed ops.
//     - Operands are converted to magnitudes in IDLE.
//     - In FIN, negate the product/quotient if operand signs differ.
//     - The remainder takes the dividend's sign.
//   - Undefined: md_op[1] is ignored and every op is unsigned. The fix-up logic is not compiled.
// STRUCTURE
//   - Shared header pipe_defs.vh holds:
//     - op codes MD_MULTU/MD_DIVU/MD_MULT/MD_DIV
//     - FSM state codes S_IDLE/S_RUN/S_FIN (2 bits)
//   - One sub-module, muldiv_step: combinational single iteration (add-shift or trial-subtract-shift).
//     - Inputs: accumulator, operand, op. Output: next accumulator.
//   - FSM, counter, HI/LO and the stall logic stay in pipe_muldiv_ctrl.
// TESTING
//   1. multu a=32'hFFFFFFFF, b=2 -> md_done at t+33; hi=1, lo=32'hFFFFFFFE.
//   2. divu a=100, b=7 -> lo=14, hi=2. divu b=0, a=5 -> done at t+2; hi=5, lo=32'hFFFFFFFF.
//   3. mult a=-3, b=5:
//      - with SIGNED_EN: hi=32'hFFFFFFFF, lo=32'hFFFFFFF1
//      - without SIGNED_EN: hi=4, lo=32'hFFFFFFF1
//   4. div a=-7, b=2 with SIGNED_EN -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
//   5. mult in flight, hilo_rd=1 at t+5 -> md_wpcir=0 from t+5 through FIN, 1 the cycle after.
//      - mthi alone in IDLE -> hi updated next edge, no stall.
//   6. resetn=0 at t+10 of a divu -> next cycle state IDLE, hi=lo=0, md_done never pulses.

Source files
------------

// File: rtl/pipe_muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_muldiv_ctrl_pkg
//   Shared definitions for the iterative multiply/divide sequencer:
//     - md_op encodings (MD_MULTU / MD_DIVU / MD_MULT / MD_DIV)
//     - sequencer FSM state codes (S_IDLE / S_RUN / S_FIN), 2 bits
//     - small helpers that classify an md_op value
// ---------------------------------------------------------------------------
package pipe_muldiv_ctrl_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } md_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/pipe_muldiv_ctrl_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
//   One combinational iteration of the multiply/divide loop.
//   The 2*WIDTH accumulator is {upper, lower}:
//     multiply : upper = partial product, lower = remaining multiplier bits
//     divide   : upper = partial remainder, lower = dividend bits / quotient
//   Ports:
//     acc_i    in  2*WIDTH  current accumulator
//     opnd_i   in  WIDTH    multiplicand (mult) or divisor (div)
//     is_div_i in  1        1 = restoring divide step, 0 = shift-add step
//     acc_o    out 2*WIDTH  accumulator after this iteration
// ---------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set; the carry is kept by shifting it back in.
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    // Divide: the remainder shifted left by one needs WIDTH+1 bits, and a
    // set top bit of the difference means the trial subtraction borrowed.
    trial   = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    acc_o   = acc_i;
    if (is_div_i) begin
      if (!trial[WIDTH]) begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_i[0]) begin
        acc_o = {add_sum, acc_i[WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_muldiv_ctrl
//   Sequencer for an iterative multiply/divide unit that sits beside the EXE
//   stage and owns the HI/LO registers. A start in IDLE latches the operands,
//   runs WIDTH shift-add / restoring-divide steps, then writes HI/LO in FIN.
//   Divide by zero skips the loop: hi = dividend, lo = all ones, no trap.
//
//   Optional feature macro: PIPE_MULDIV_SIGNED_EN
//     defined   : md_op[1]=1 selects signed ops (magnitudes in, sign fix-up
//                 in FIN, remainder takes the dividend's sign)
//     undefined : every op is unsigned, no fix-up logic is built
//
//   Ports:
//     clock     in   1      rising-edge clock
//     resetn    in   1      synchronous active-low reset
//     md_start  in   1      ID holds a mult/div op
//     md_op     in   2      00 multu, 01 divu, 10 mult, 11 div
//     md_a      in   WIDTH  rs value (also mthi/mtlo data)
//     md_b      in   WIDTH  rt value
//     hilo_rd   in   1      ID holds mfhi/mflo
//     hi_we     in   1      ID holds mthi
//     lo_we     in   1      ID holds mtlo
//     md_wpcir  out  1      0 = stall PC and IF/ID
//     md_busy   out  1      sequencer not idle
//     md_done   out  1      one-cycle pulse when HI/LO take a result
//     hi, lo    out  WIDTH  HI / LO registers
//   CNT_W must satisfy 2**CNT_W > WIDTH.
// ---------------------------------------------------------------------------
module pipe_muldiv_ctrl
  import pipe_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  input  logic             hilo_rd,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             md_wpcir,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               fin_wait_q, fin_wait_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               start_div0;

`ifdef PIPE_MULDIV_SIGNED_EN
  logic neg_res_q, neg_res_d;
  logic neg_rem_q, neg_rem_d;
  logic op_signed;

  assign op_signed = op_is_signed(md_op);
  assign a_mag     = (op_signed && md_a[WIDTH-1]) ? (~md_a + 1'b1) : md_a;
  assign b_mag     = (op_signed && md_b[WIDTH-1]) ? (~md_b + 1'b1) : md_b;

  // Sign fix-up on the unsigned magnitude result.
  always_comb begin
    result = acc_q;
    if (is_div_q) begin
      if (neg_res_q) result[WIDTH-1:0]       = ~acc_q[WIDTH-1:0] + 1'b1;
      if (neg_rem_q) result[2*WIDTH-1:WIDTH] = ~acc_q[2*WIDTH-1:WIDTH] + 1'b1;
    end else if (neg_res_q) begin
      result = ~acc_q + 1'b1;
    end
  end
`else
  assign a_mag  = md_a;
  assign b_mag  = md_b;
  assign result = acc_q;
`endif

  assign start_div0 = op_is_div(md_op) && (md_b == '0);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    fin_wait_d = fin_wait_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
`ifdef PIPE_MULDIV_SIGNED_EN
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (md_start) begin
          // A start wins over a same-cycle move-to.
          is_div_d = op_is_div(md_op);
          count_d  = '0;
          opnd_d   = b_mag;
          if (start_div0) begin
            // Result is preloaded; the extra FIN cycle keeps the write two
            // edges after acceptance.
            acc_d      = {md_a, {WIDTH{1'b1}}};
            fin_wait_d = 1'b1;
            state_d    = S_FIN;
`ifdef PIPE_MULDIV_SIGNED_EN
            neg_res_d  = 1'b0;
            neg_rem_d  = 1'b0;
`endif
          end else begin
            acc_d      = {{WIDTH{1'b0}}, a_mag};
            fin_wait_d = 1'b0;
            state_d    = S_RUN;
`ifdef PIPE_MULDIV_SIGNED_EN
            neg_res_d  = op_signed && (md_a[WIDTH-1] ^ md_b[WIDTH-1]);
            neg_rem_d  = op_signed && md_a[WIDTH-1];
`endif
          end
        end else begin
          if (hi_we) hi_d = md_a;
          if (lo_we) lo_d = md_a;
        end
      end
      S_RUN: begin
        acc_d   = step_acc;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        if (fin_wait_q) begin
          fin_wait_d = 1'b0;
        end else begin
          hi_d    = result[2*WIDTH-1:WIDTH];
          lo_d    = result[WIDTH-1:0];
          done_d  = 1'b1;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      fin_wait_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PIPE_MULDIV_SIGNED_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      fin_wait_q <= fin_wait_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef PIPE_MULDIV_SIGNED_EN
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  // ID re-presents any HI/LO user or second op until the sequencer is idle.
  assign md_wpcir = ~(busy_q & (md_start | hilo_rd | hi_we | lo_we));
  assign md_busy  = busy_q;
  assign md_done  = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_muldiv_ctrl
//   Random and directed mult/div/move-to traffic. Expected HI/LO results and
//   completion edges are queued at acceptance; a negedge monitor compares
//   busy / stall / done / HI / LO every cycle and pops on md_done.
//   Build with +define+PIPE_MULDIV_SIGNED_EN to exercise signed ops.
// ---------------------------------------------------------------------------
module tb_pipe_muldiv_ctrl;
  import pipe_muldiv_ctrl_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         md_start = 1'b0;
  logic [1:0]   md_op = 2'b00;
  logic [W-1:0] md_a = '0;
  logic [W-1:0] md_b = '0;
  logic         hilo_rd = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic         md_wpcir, md_busy, md_done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           done_edge;
  } exp_t;

  exp_t         sb[$];
  int           win_t = -1;
  int           win_d = -1;
  int           d_last = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  bit           mon_en = 1'b0;

  pipe_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .hilo_rd  (hilo_rd),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .md_wpcir (md_wpcir),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural meaning of each op.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit              sgn;
    longint          sa, sbv, q, r;
    longint unsigned p;
`ifdef PIPE_MULDIV_SIGNED_EN
    sgn = op[1];
`else
    sgn = 1'b0;
`endif
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op[0]) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
    end
    if (sgn) p = longint'(sa * sbv);
    else     p = {32'd0, a} * {32'd0, b};
    return p;
  endfunction

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Holds md_start until the op is accepted (the first edge where the unit
  // is idle), then records the expected result and completion edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int          t, lat;
    exp_t        e;
    logic [63:0] r;
    t   = (cyc + 1 > d_last + 1) ? cyc + 1 : d_last + 1;
    lat = (op[0] && b == 32'd0) ? 2 : 33;
    r   = ref_result(op, a, b);
    md_start = 1'b1;
    md_op    = op;
    md_a     = a;
    md_b     = b;
    wait_to(t);
    md_start = 1'b0;
    md_a     = $urandom;
    md_b     = $urandom;
    e.hi        = r[63:32];
    e.lo        = r[31:0];
    e.done_edge = t + lat;
    sb.push_back(e);
    win_t  = t;
    win_d  = t + lat;
    d_last = win_d;
  endtask

  task automatic move_to(input bit to_hi, input logic [31:0] v);
    int t;
    t = (cyc + 1 > d_last + 1) ? cyc + 1 : d_last + 1;
    md_a = v;
    if (to_hi) hi_we = 1'b1;
    else       lo_we = 1'b1;
    wait_to(t);
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (to_hi) m_hi = v;
    else       m_lo = v;
    d_last = t;
  endtask

  // Monitor: compares every cycle against the model window of the current op.
  always @(negedge clock) begin
    if (mon_en) begin : mon
      bit   eb;
      exp_t e;
      eb = (cyc >= win_t) && (cyc < win_d);
      chk("busy",  64'(md_busy),  64'(eb));
      chk("wpcir", 64'(md_wpcir), 64'(!(eb && (md_start || hilo_rd || hi_we || lo_we))));
      chk("done",  64'(md_done),  64'(cyc == win_d));
      if (md_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected at cycle %0d: got pulse, expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_edge", 64'(cyc), 64'(e.done_edge));
          chk("hi_result", 64'(hi), 64'(e.hi));
          chk("lo_result", 64'(lo), 64'(e.lo));
          $display("op done cycle %0d: hi=%h lo=%h", cyc, hi, lo);
          m_hi = e.hi;
          m_lo = e.lo;
        end
      end else begin
        chk("hi_hold", 64'(hi), 64'(m_hi));
        chk("lo_hold", 64'(lo), 64'(m_lo));
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    logic [31:0] a, b;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    d_last = cyc;

    // Directed cases from the operation list.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    issue(MD_DIVU,  32'd100,       32'd7);
    issue(MD_DIVU,  32'd5,         32'd0);
    issue(MD_MULT,  32'hFFFF_FFFD, 32'd5);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);

    // Read of HI/LO while a mult is in flight stalls through FIN.
    issue(MD_MULT, $urandom, $urandom);
    wait_to(win_t + 4);
    hilo_rd = 1'b1;
    wait_to(win_d);
    hilo_rd = 1'b0;

    move_to(1'b1, 32'hA5A5_0001);
    move_to(1'b0, 32'h5A5A_0002);

    // Reset in the middle of a divide: no result, HI/LO cleared.
    issue(MD_DIVU, $urandom, 32'd13);
    t0 = win_t;
    wait_to(t0 + 9);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    sb.delete();
    win_t  = -1;
    win_d  = -1;
    d_last = cyc;
    m_hi   = '0;
    m_lo   = '0;
    $display("reset applied at cycle %0d", cyc);
    wait_to(cyc + 40);

    // Randomised traffic, including back-to-back starts and move-tos.
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = $urandom_range(0, 255);
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) move_to(1'($urandom_range(0, 1)), a);
      else issue(2'($urandom_range(0, 3)), a, b);
      if ($urandom_range(0, 3) == 0) wait_to(cyc + $urandom_range(1, 40));
    end

    wait_to(d_last + 3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
